// File: rtl/abc_sweep_sequencer.sv
// Sweeps {a,b,c} codes through a registered truth-table decoder, waits LAT clocks per code,
// and captures y/z into an 8-entry result file indexed by code, with a y-high tally.
module abc_sweep_sequencer #(
    parameter int LAT        = 1,
    parameter int NVEC       = 8,
    parameter int START_CODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y_in,
    input  logic       z_in,
    output logic       busy,
    output logic       done,
    input  logic [2:0] rd_addr,
    output logic       rd_y,
    output logic       rd_z,
    output logic       rd_vld,
    output logic [3:0] y_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    localparam logic [2:0] LAT_M1  = 3'(LAT - 1);
    localparam logic [2:0] NVEC_M1 = 3'(NVEC - 1);
    localparam logic [2:0] FIRST   = 3'(START_CODE);

    state_t     state, state_nxt;
    logic [2:0] code, idx, wcnt;
    logic [7:0] res_y, res_z, valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (!hold && wcnt == LAT_M1) state_nxt = CAPTURE;
            CAPTURE: if (!hold) state_nxt = (idx == NVEC_M1) ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == CAPTURE);
        done = (state == DONE);
    end

    // Sweep datapath: code/index/wait counters and the result file; hold freezes it all.
    always_ff @(posedge clk) begin
        if (rst) begin
            code    <= 3'd0;
            idx     <= 3'd0;
            wcnt    <= 3'd0;
            res_y   <= 8'd0;
            res_z   <= 8'd0;
            valid   <= 8'd0;
            y_count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        code    <= FIRST;
                        idx     <= 3'd0;
                        wcnt    <= 3'd0;
                        valid   <= 8'd0;
                        y_count <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (!hold) wcnt <= (wcnt == LAT_M1) ? 3'd0 : wcnt + 3'd1;
                end
                CAPTURE: begin
                    if (!hold) begin
                        res_y[code] <= y_in;
                        res_z[code] <= z_in;
                        valid[code] <= 1'b1;
                        // An unknown y_in must not count, so only a definite 1 increments.
                        if (y_in == 1'b1) y_count <= y_count + 4'd1;
                        if (idx != NVEC_M1) begin
                            idx  <= idx + 3'd1;
                            code <= code + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c} = code;
    assign rd_vld    = valid[rd_addr];
    assign rd_y      = rd_vld & res_y[rd_addr];
    assign rd_z      = rd_vld ? res_z[rd_addr] : 1'b0;
endmodule

// File: tb/tb_abc_sweep_sequencer.sv
// Directed bench for abc_sweep_sequencer: three instances (defaults, wrapped short sweep,
// LAT=3) each driving a behavioural decoder y=a&b&~c, z=a&b with matching latency.
module tb_abc_sweep_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Instance d: defaults
    logic start_d = 0, hold_d = 0, a_d, b_d, c_d, y_d, z_d, busy_d, done_d, rdy_d, rdz_d, rdv_d;
    logic [2:0] rda_d = 0;
    logic [3:0] ycnt_d;
    abc_sweep_sequencer dut_d (
        .clk(clk), .rst(rst), .start(start_d), .hold(hold_d), .a(a_d), .b(b_d), .c(c_d),
        .y_in(y_d), .z_in(z_d), .busy(busy_d), .done(done_d), .rd_addr(rda_d),
        .rd_y(rdy_d), .rd_z(rdz_d), .rd_vld(rdv_d), .y_count(ycnt_d));
    always_ff @(posedge clk) begin
        y_d <= a_d & b_d & ~c_d;
        z_d <= a_d & b_d;
    end

    // Instance w: START_CODE=6, NVEC=3
    logic start_w = 0, hold_w = 0, a_w, b_w, c_w, y_w, z_w, busy_w, done_w, rdy_w, rdz_w, rdv_w;
    logic [2:0] rda_w = 0;
    logic [3:0] ycnt_w;
    abc_sweep_sequencer #(.LAT(1), .NVEC(3), .START_CODE(6)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .hold(hold_w), .a(a_w), .b(b_w), .c(c_w),
        .y_in(y_w), .z_in(z_w), .busy(busy_w), .done(done_w), .rd_addr(rda_w),
        .rd_y(rdy_w), .rd_z(rdz_w), .rd_vld(rdv_w), .y_count(ycnt_w));
    always_ff @(posedge clk) begin
        y_w <= a_w & b_w & ~c_w;
        z_w <= a_w & b_w;
    end

    // Instance l: LAT=3 with a three-stage decoder
    logic start_l = 0, hold_l = 0, a_l, b_l, c_l, y_l, z_l, busy_l, done_l, rdy_l, rdz_l, rdv_l;
    logic [2:0] rda_l = 0;
    logic [3:0] ycnt_l;
    logic [1:0] p1_l, p2_l, p3_l;
    abc_sweep_sequencer #(.LAT(3), .NVEC(8), .START_CODE(0)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .hold(hold_l), .a(a_l), .b(b_l), .c(c_l),
        .y_in(y_l), .z_in(z_l), .busy(busy_l), .done(done_l), .rd_addr(rda_l),
        .rd_y(rdy_l), .rd_z(rdz_l), .rd_vld(rdv_l), .y_count(ycnt_l));
    always_ff @(posedge clk) begin
        p1_l <= {a_l & b_l & ~c_l, a_l & b_l};
        p2_l <= p1_l;
        p3_l <= p2_l;
    end
    assign {y_l, z_l} = p3_l;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy_d, done_d, a_d, b_d, c_d} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=00000", {busy_d, done_d, a_d, b_d, c_d});
        end
        checks++;
        if (ycnt_d !== 4'd0) begin
            failures++;
            $display("FAIL reset_ycnt got=%0d exp=0", ycnt_d);
        end
        for (int i = 0; i < 8; i++) begin
            rda_d = 3'(i);
            #1;
            checks++;
            if (rdv_d !== 1'b0) begin
                failures++;
                $display("FAIL reset_vld addr=%0d got=%b exp=0", i, rdv_d);
            end
        end
    endtask

    task automatic test_default_sweep();
        logic [2:0] exp_code;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int e = 0; e <= 18; e++) begin
            if (e > 0) tick();
            exp_code = (e / 2 > 7) ? 3'd7 : 3'(e / 2);
            checks++;
            if ({a_d, b_d, c_d} !== exp_code || done_d !== (e == 16) || busy_d !== (e < 16)) begin
                failures++;
                $display("FAIL dflt_seq e=%0d got code=%0d done=%b busy=%b exp code=%0d done=%b busy=%b",
                         e, {a_d, b_d, c_d}, done_d, busy_d, exp_code, e == 16, e < 16);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rda_d = 3'(i);
            #1;
            checks++;
            if ({rdv_d, rdy_d, rdz_d} !== {1'b1, i == 6, i >= 6}) begin
                failures++;
                $display("FAIL dflt_read addr=%0d got vyz=%b exp vyz=%b", i, {rdv_d, rdy_d, rdz_d},
                         {1'b1, i == 6, i >= 6});
            end
        end
        checks++;
        if (ycnt_d !== 4'd1) begin
            failures++;
            $display("FAIL dflt_ycnt got=%0d exp=1", ycnt_d);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_code;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e > 0) tick();
            exp_code = 3'(6 + ((e / 2 > 2) ? 2 : e / 2));
            checks++;
            if ({a_w, b_w, c_w} !== exp_code || done_w !== (e == 6)) begin
                failures++;
                $display("FAIL wrap_seq e=%0d got code=%0d done=%b exp code=%0d done=%b",
                         e, {a_w, b_w, c_w}, done_w, exp_code, e == 6);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rda_w = 3'(i);
            #1;
            checks++;
            if ({rdv_w, rdy_w, rdz_w} !== {(i >= 6 || i == 0), i == 6, i >= 6}) begin
                failures++;
                $display("FAIL wrap_read addr=%0d got vyz=%b exp vyz=%b", i, {rdv_w, rdy_w, rdz_w},
                         {(i >= 6 || i == 0), i == 6, i >= 6});
            end
        end
        checks++;
        if (ycnt_w !== 4'd1) begin
            failures++;
            $display("FAIL wrap_ycnt got=%0d exp=1", ycnt_w);
        end
    endtask

    task automatic test_hold();
        logic [2:0] exp_code;
        int ee;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int e = 0; e <= 23; e++) begin
            if (e > 0) tick();
            ee = (e < 7) ? e : (e <= 11) ? 6 : e - 5;
            exp_code = (ee / 2 > 7) ? 3'd7 : 3'(ee / 2);
            checks++;
            if ({a_d, b_d, c_d} !== exp_code || done_d !== (e == 21)) begin
                failures++;
                $display("FAIL hold_seq e=%0d got code=%0d done=%b exp code=%0d done=%b",
                         e, {a_d, b_d, c_d}, done_d, exp_code, e == 21);
            end
            hold_d = (e >= 6 && e <= 10);
        end
        for (int i = 0; i < 8; i++) begin
            rda_d = 3'(i);
            #1;
            checks++;
            if ({rdv_d, rdy_d, rdz_d} !== {1'b1, i == 6, i >= 6}) begin
                failures++;
                $display("FAIL hold_read addr=%0d got vyz=%b", i, {rdv_d, rdy_d, rdz_d});
            end
        end
        checks++;
        if (ycnt_d !== 4'd1) begin
            failures++;
            $display("FAIL hold_ycnt got=%0d exp=1", ycnt_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_code;
        int pulses;
        pulses = 0;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            if (e > 0) tick();
            exp_code = (e / 2 > 7) ? 3'd7 : 3'(e / 2);
            if (done_d === 1'b1) pulses++;
            checks++;
            if ({a_d, b_d, c_d} !== exp_code || done_d !== (e == 16) || busy_d !== (e < 16)) begin
                failures++;
                $display("FAIL b2b_seq e=%0d got code=%0d done=%b busy=%b exp code=%0d done=%b",
                         e, {a_d, b_d, c_d}, done_d, busy_d, exp_code, e == 16);
            end
            start_d = (e == 3 || e == 16);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [2:0] exp_code;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy_d, done_d, a_d, b_d, c_d} !== 5'b0 || ycnt_d !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_ctl got bdabc=%b ycnt=%0d exp 00000/0", {busy_d, done_d, a_d, b_d, c_d}, ycnt_d);
        end
        for (int i = 0; i < 8; i++) begin
            rda_d = 3'(i);
            #1;
            checks++;
            if (rdv_d !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_vld addr=%0d got=%b exp=0", i, rdv_d);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (done_d !== 1'b0 || busy_d !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_idle k=%0d got done=%b busy=%b exp 0/0", k, done_d, busy_d);
            end
        end
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int e = 0; e <= 17; e++) begin
            if (e > 0) tick();
            exp_code = (e / 2 > 7) ? 3'd7 : 3'(e / 2);
            checks++;
            if ({a_d, b_d, c_d} !== exp_code || done_d !== (e == 16)) begin
                failures++;
                $display("FAIL rstmid_rerun e=%0d got code=%0d done=%b exp code=%0d done=%b",
                         e, {a_d, b_d, c_d}, done_d, exp_code, e == 16);
            end
        end
        checks++;
        if (ycnt_d !== 4'd1) begin
            failures++;
            $display("FAIL rstmid_ycnt got=%0d exp=1", ycnt_d);
        end
    endtask

    task automatic test_lat3();
        logic [2:0] exp_code;
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        for (int e = 0; e <= 34; e++) begin
            if (e > 0) tick();
            exp_code = (e / 4 > 7) ? 3'd7 : 3'(e / 4);
            checks++;
            if ({a_l, b_l, c_l} !== exp_code || done_l !== (e == 32) || busy_l !== (e < 32)) begin
                failures++;
                $display("FAIL lat3_seq e=%0d got code=%0d done=%b busy=%b exp code=%0d done=%b",
                         e, {a_l, b_l, c_l}, done_l, busy_l, exp_code, e == 32);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rda_l = 3'(i);
            #1;
            checks++;
            if ({rdv_l, rdy_l, rdz_l} !== {1'b1, i == 6, i >= 6}) begin
                failures++;
                $display("FAIL lat3_read addr=%0d got vyz=%b exp vyz=%b", i, {rdv_l, rdy_l, rdz_l},
                         {1'b1, i == 6, i >= 6});
            end
        end
        checks++;
        if (ycnt_l !== 4'd1) begin
            failures++;
            $display("FAIL lat3_ycnt got=%0d exp=1", ycnt_l);
        end
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_wrap();
        repeat (2) tick();
        test_hold();
        repeat (2) tick();
        test_back_to_back();
        repeat (2) tick();
        test_reset_mid_sweep();
        repeat (2) tick();
        test_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
